// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - control sequencer bus: instruction/handshake inputs, datapath strobes and status
interface control_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [31:0]      ir;
  logic             mem_ready;
  logic [23:0]      src_oh;
  logic [15:0]      reg_in;
  logic             mar_in;
  logic             mdr_in;
  logic             ir_in;
  logic             pc_in;
  logic             y_in;
  logic             z_in;
  logic             inc_pc;
  logic             mem_read;
  logic [3:0]       alu_op;
  logic             halted;
  logic             illegal_op;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  start, ir, mem_ready,
    output src_oh, reg_in, mar_in, mdr_in, ir_in, pc_in, y_in, z_in, inc_pc, mem_read,
           alu_op, halted, illegal_op, instr_count
  );

  modport slave (
    output start, ir, mem_ready,
    input  src_oh, reg_in, mar_in, mdr_in, ir_in, pc_in, y_in, z_in, inc_pc, mem_read,
           alu_op, halted, illegal_op, instr_count
  );
endinterface

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - fetch/execute control-step FSM driving one-hot bus sources and datapath strobes
// Optional ILLEGAL_TRAP_EN: illegal opcodes set a sticky flag and halt instead of acting as NOP.
module control_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic                  clock,
  input  logic                  clear,
  control_sequencer_if.master   bus
);
  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, HALT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [4:0]       op;
  logic [3:0]       ra, rb, rc;
  logic             is_alu, is_nop, is_halt;
  logic             unused_ir;

  assign op        = bus.ir[31:27];
  assign ra        = bus.ir[26:23];
  assign rb        = bus.ir[22:19];
  assign rc        = bus.ir[18:15];
  assign unused_ir = ^bus.ir[14:0];
  assign is_alu    = (op[4:2] == 3'b000);
  assign is_nop    = (op == 5'b11010);
  assign is_halt   = (op == 5'b11011);

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
  assign bus.illegal_op = illegal_q;
`else
  assign bus.illegal_op = 1'b0;
`endif

  assign bus.instr_count = count_q;
  assign bus.halted      = (state_q == HALT);

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
`ifdef ILLEGAL_TRAP_EN
    illegal_d    = illegal_q;
`endif
    bus.src_oh   = '0;
    bus.reg_in   = '0;
    bus.mar_in   = 1'b0;
    bus.mdr_in   = 1'b0;
    bus.ir_in    = 1'b0;
    bus.pc_in    = 1'b0;
    bus.y_in     = 1'b0;
    bus.z_in     = 1'b0;
    bus.inc_pc   = 1'b0;
    bus.mem_read = 1'b0;
    bus.alu_op   = '0;
    case (state_q)
      IDLE: if (bus.start) state_d = T0;
      T0: begin
        bus.src_oh[20] = 1'b1;
        bus.mar_in     = 1'b1;
        bus.inc_pc     = 1'b1;
        bus.z_in       = 1'b1;
        state_d        = T1;
      end
      // Hold the read request and PC reload until memory returns data.
      T1: begin
        bus.src_oh[19] = 1'b1;
        bus.pc_in      = 1'b1;
        bus.mem_read   = 1'b1;
        bus.mdr_in     = 1'b1;
        if (bus.mem_ready) state_d = T2;
      end
      T2: begin
        bus.src_oh[21] = 1'b1;
        bus.ir_in      = 1'b1;
        state_d        = T3;
      end
      T3: begin
        if (is_alu) begin
          bus.src_oh = 24'd1 << rb;
          bus.y_in   = 1'b1;
          state_d    = T4;
        end else if (is_nop) begin
          count_d = count_q + CNT_W'(1);
          state_d = T0;
        end else if (is_halt) begin
          count_d = count_q + CNT_W'(1);
          state_d = HALT;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          illegal_d = 1'b1;
          state_d   = HALT;
`else
          count_d = count_q + CNT_W'(1);
          state_d = T0;
`endif
        end
      end
      T4: begin
        bus.src_oh = 24'd1 << rc;
        bus.alu_op = {2'b00, op[1:0]};
        bus.z_in   = 1'b1;
        state_d    = T5;
      end
      T5: begin
        bus.src_oh[19] = 1'b1;
        bus.reg_in     = 16'd1 << ra;
        count_d        = count_q + CNT_W'(1);
        state_d        = T0;
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q   <= IDLE;
      count_q   <= '0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - randomized bench for control_sequencer against a per-instruction trace model
module tb_control_sequencer;
  localparam int CW   = 4;
  localparam int MASK = (1 << CW) - 1;

  logic clock = 1'b0;
  logic clear;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_cnt   = 0;
  logic m_ill   = 1'b0;

  control_sequencer_if #(.CNT_W(CW)) bus();

  control_sequencer #(.CNT_W(CW)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] mk(logic [23:0] src, logic [15:0] rin, logic [7:0] st,
                                     logic [3:0] alu, logic h);
    return {10'b0, src, rin, st, alu, h, m_ill};
  endfunction

  function automatic logic [63:0] dut_vec();
    return {10'b0, bus.src_oh, bus.reg_in, bus.mar_in, bus.mdr_in, bus.ir_in, bus.pc_in,
            bus.y_in, bus.z_in, bus.inc_pc, bus.mem_read, bus.alu_op, bus.halted, bus.illegal_op};
  endfunction

  task automatic check_cycle(input string tag, input logic [63:0] exp);
    check(tag, dut_vec(), exp);
    check("onehot", 64'($countones(bus.src_oh) <= 1), 64'd1);
  endtask

  // Strobe byte order: mar_in mdr_in ir_in pc_in y_in z_in inc_pc mem_read.
  task automatic run_instr(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb,
                           input logic [3:0] rc, input int wait_n);
    logic [63:0] exp_q[$];
    logic        mr_q[$];
    logic [31:0] word;
    int          t2;
    bit          counted;
    bit          ends_halt;
    bit          traps;
    counted   = 1'b0;
    ends_halt = 1'b0;
    traps     = 1'b0;
    word = {op, ra, rb, rc, 15'($urandom)};
    exp_q.push_back(mk(24'd1 << 20, 16'd0, 8'b1000_0110, 4'd0, 1'b0));
    mr_q.push_back(1'($urandom));
    for (int i = 0; i <= wait_n; i++) begin
      exp_q.push_back(mk(24'd1 << 19, 16'd0, 8'b0101_0001, 4'd0, 1'b0));
      mr_q.push_back(i == wait_n);
    end
    t2 = exp_q.size();
    exp_q.push_back(mk(24'd1 << 21, 16'd0, 8'b0010_0000, 4'd0, 1'b0));
    mr_q.push_back(1'($urandom));
    if (op <= 5'd3) begin
      exp_q.push_back(mk(24'd1 << rb, 16'd0, 8'b0000_1000, 4'd0, 1'b0));
      mr_q.push_back(1'($urandom));
      exp_q.push_back(mk(24'd1 << rc, 16'd0, 8'b0000_0100, {2'b00, op[1:0]}, 1'b0));
      mr_q.push_back(1'($urandom));
      exp_q.push_back(mk(24'd1 << 19, 16'd1 << ra, 8'b0, 4'd0, 1'b0));
      mr_q.push_back(1'($urandom));
      counted = 1'b1;
    end else begin
      exp_q.push_back(mk(24'd0, 16'd0, 8'b0, 4'd0, 1'b0));
      mr_q.push_back(1'($urandom));
      if (op == 5'b11010) counted = 1'b1;
      else if (op == 5'b11011) begin
        counted   = 1'b1;
        ends_halt = 1'b1;
      end else begin
`ifdef ILLEGAL_TRAP_EN
        traps     = 1'b1;
        ends_halt = 1'b1;
`else
        counted = 1'b1;
`endif
      end
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      check_cycle($sformatf("op%0d_step%0d", op, k), exp_q[k]);
      bus.ir        = (k >= t2) ? word : $urandom;
      bus.mem_ready = mr_q[k];
      bus.start     = 1'($urandom);
      @(negedge clock);
    end
    if (counted) m_cnt = (m_cnt + 1) & MASK;
    if (traps) m_ill = 1'b1;
    check("count", 64'(bus.instr_count), 64'(m_cnt));
    if (ends_halt) check_cycle("halt_entry", mk(24'd0, 16'd0, 8'b0, 4'd0, 1'b1));
    bus.start = 1'b0;
  endtask

  task automatic reset_and_start();
    clear     = 1'b0;
    bus.start = 1'b1;
    @(negedge clock);
    m_cnt = 0;
    m_ill = 1'b0;
    check_cycle("reset_idle", mk(24'd0, 16'd0, 8'b0, 4'd0, 1'b0));
    check("reset_count", 64'(bus.instr_count), 64'd0);
    clear = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    clear         = 1'b0;
    bus.start     = 1'b0;
    bus.ir        = '0;
    bus.mem_ready = 1'b0;
    repeat (2) @(negedge clock);
    check_cycle("reset_idle", mk(24'd0, 16'd0, 8'b0, 4'd0, 1'b0));
    check("reset_count", 64'(bus.instr_count), 64'd0);
    clear = 1'b1;
    bus.mem_ready = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check_cycle("idle_wait", mk(24'd0, 16'd0, 8'b0, 4'd0, 1'b0));
    end
    bus.start = 1'b1;
    @(negedge clock);

    run_instr(5'b00000, 4'd3, 4'd1, 4'd2, 0);
    run_instr(5'b00000, 4'd7, 4'd4, 4'd9, 4);
    run_instr(5'b00001, 4'd5, 4'd5, 4'd5, 1);
    run_instr(5'b00010, 4'd15, 4'd0, 4'd14, 2);
    run_instr(5'b00011, 4'd0, 4'd15, 4'd0, 0);
    run_instr(5'b11010, 4'd0, 4'd0, 4'd0, 3);

    for (int n = 0; n < 30; n++) begin
      int sel;
      sel = $urandom_range(0, 4);
      run_instr((sel == 4) ? 5'b11010 : 5'(sel), 4'($urandom), 4'($urandom), 4'($urandom),
                $urandom_range(0, 3));
    end

    do run_instr(5'b11010, 4'($urandom), 4'($urandom), 4'($urandom), 0);
    while (m_cnt != 0);
    check("wrap_zero", 64'(bus.instr_count), 64'd0);

    bus.mem_ready = 1'b0;
    @(negedge clock);
    check_cycle("t1_wait", mk(24'd1 << 19, 16'd0, 8'b0101_0001, 4'd0, 1'b0));
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    m_cnt = 0;
    check_cycle("abort_idle", mk(24'd0, 16'd0, 8'b0, 4'd0, 1'b0));
    clear = 1'b1;
    bus.mem_ready = 1'b1;
    @(negedge clock);
    check_cycle("abort_stay_idle", mk(24'd0, 16'd0, 8'b0, 4'd0, 1'b0));
    bus.start = 1'b1;
    @(negedge clock);

    run_instr(5'b00001, 4'd2, 4'd3, 4'd4, 1);
    run_instr(5'b11011, 4'd0, 4'd0, 4'd0, 2);
    for (int n = 0; n < 10; n++) begin
      bus.start     = 1'b1;
      bus.mem_ready = 1'($urandom);
      @(negedge clock);
      check_cycle("halt_hold", mk(24'd0, 16'd0, 8'b0, 4'd0, 1'b1));
      check("halt_count", 64'(bus.instr_count), 64'(m_cnt));
    end
    reset_and_start();

    run_instr(5'b00000, 4'd1, 4'd2, 4'd3, 0);
    run_instr(5'b10101, 4'd6, 4'd7, 4'd8, 1);
    check("illegal_flag", 64'(bus.illegal_op), 64'(m_ill));
    clear = 1'b0;
    @(negedge clock);
    m_ill = 1'b0;
    m_cnt = 0;
    check_cycle("final_idle", mk(24'd0, 16'd0, 8'b0, 4'd0, 1'b0));
    check("final_count", 64'(bus.instr_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
